// File: rtl/vga_pkg.sv
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared VGA 640x480@60 timing constants, colour and control types
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CLK_DIV  = 4;
  localparam int PIPE_LAT = 1;

  typedef logic [11:0] rgb_t;
  localparam rgb_t COLOR_BLACK = 12'h000;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vga_ctl_t;

  // Idle/blank control word: no display enable, both syncs inactive (high)
  localparam vga_ctl_t CTL_IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

`default_nettype wire

// File: rtl/vga_clk_div.sv
// ============================================================================
//  Module   : vga_clk_div
//  Purpose  : Pixel-rate strobe generator; pix_en high one clk in CLK_DIV
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int            W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  DIV_LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div_cnt;

  // Free-running modulo-CLK_DIV counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + W'(1);
    end
  end

  assign pix_en = (div_cnt == DIV_LAST);

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
//  Module   : vga_timing_ctrl
//  Purpose  : VGA scan counters, sync/blank decode, colour output gating and
//             per-frame tick. Define VGA_SYNC_COMP_EN to delay de/hs/vs by
//             PIPE_LAT clks so they line up with a BRAM-backed colour path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_ctrl #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int PIPE_LAT = vga_pkg::PIPE_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] rgb_in,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_en,
  output logic        hs,
  output logic        vs,
  output logic [11:0] rgb_out,
  output logic        frame_tick
);

  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All counter compares are done in 10-bit unsigned arithmetic
  localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       de_c;
  logic       hs_c;
  logic       vs_c;
  vga_ctl_t   ctl_r;
  vga_ctl_t   ctl_out;

  vga_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // Scan position: h advances per pixel, v advances when h wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign de_c = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_c = ~((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_c = ~((v_cnt >= VS_START) && (v_cnt < VS_END));

  // Register decoded coordinates and control one clk behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_r <= CTL_IDLE;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      ctl_r <= '{de: de_c, hs: hs_c, vs: vs_c};
      pix_x <= de_c ? h_cnt : 10'd0;
      pix_y <= de_c ? v_cnt[8:0] : 9'd0;
    end
  end

`ifdef VGA_SYNC_COMP_EN
  vga_ctl_t ctl_pipe [PIPE_LAT];

  // Delay de/hs/vs so they match the colour returned through the BRAM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) ctl_pipe[i] <= CTL_IDLE;
    end else begin
      ctl_pipe[0] <= ctl_r;
      for (int i = 1; i < PIPE_LAT; i++) ctl_pipe[i] <= ctl_pipe[i-1];
    end
  end

  assign ctl_out = ctl_pipe[PIPE_LAT-1];
`else
  localparam int unused_pipe_lat = PIPE_LAT;
  assign ctl_out = ctl_r;
`endif

  // Pin colour: pass sampled colour only during active video, black otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= COLOR_BLACK;
    end else begin
      rgb_out <= ctl_out.de ? rgb_in : COLOR_BLACK;
    end
  end

  assign hs         = ctl_out.hs;
  assign vs         = ctl_out.vs;
  assign frame_tick = pix_en & h_last & v_last;

endmodule

`default_nettype wire
